// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port between N_REQ producers.
// A grant is held for up to MAX_BURST pushes, then priority rotates past the owner.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 3,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4,
    parameter int W_REQ     = $clog2(N_REQ),
    parameter int W_BURST   = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_w_en,
    output logic [WIDTH-1:0]       fifo_w_data,
    input  logic                   fifo_full,
    output logic                   busy,
    output logic [W_REQ-1:0]       owner
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [W_REQ-1:0]   LAST_IDX  = W_REQ'(N_REQ - 1);
    localparam logic [W_BURST-1:0] LAST_BEAT = W_BURST'(MAX_BURST - 1);

    logic [0:0]         state_q, state_d;
    logic [W_REQ-1:0]   owner_q, owner_d;
    logic [W_REQ-1:0]   rr_ptr_q, rr_ptr_d;
    logic [W_BURST-1:0] burst_cnt_q, burst_cnt_d;
    logic               busy_q;

    logic               push;
    logic               grant_any;
    logic [W_REQ-1:0]   grant_sel;
    logic [W_REQ-1:0]   owner_inc;
    logic [2*N_REQ-1:0] valid_dbl;
    logic [N_REQ-1:0]   valid_rot;
    logic [WIDTH-1:0]   words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign words[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Push is the only combinational path from req_valid/fifo_full to the outputs.
    assign push        = !rst && (state_q == S_BURST) && req_valid[owner_q] && !fifo_full;
    assign fifo_w_en   = push;
    assign req_ready   = push ? ({{(N_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
    assign fifo_w_data = words[owner_q];
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign owner_inc   = (owner_q == LAST_IDX) ? '0 : owner_q + W_REQ'(1);

    // Rotate the request vector so bit 0 is rr_ptr, then take the lowest set bit.
    always_comb begin
        int sum;
        sum       = 0;
        grant_any = 1'b0;
        grant_sel = rr_ptr_q;
        valid_dbl = {req_valid, req_valid} >> rr_ptr_q;
        valid_rot = valid_dbl[N_REQ-1:0];
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_any && valid_rot[k]) begin
                grant_any = 1'b1;
                sum       = int'(rr_ptr_q) + k;
                if (sum >= N_REQ) sum = sum - N_REQ;
                grant_sel = W_REQ'(sum);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d     = S_BURST;
                    owner_d     = grant_sel;
                    burst_cnt_d = '0;
                end
            end
            S_BURST: begin
                if (!fifo_full) begin
                    if (!req_valid[owner_q]) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = owner_inc;
                    end else begin
                        burst_cnt_d = burst_cnt_q + W_BURST'(1);
                        if (burst_cnt_q == LAST_BEAT) begin
                            state_d  = S_IDLE;
                            rr_ptr_d = owner_inc;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            busy_q      <= (state_d == S_BURST);
        end
    end

    // A push into a full FIFO would lose a word; the push term makes it unreachable.
    no_push_on_full: assert property (@(posedge clk) disable iff (rst) !(fifo_w_en && fifo_full))
        else $warning("fifo_wr_arbiter: push while fifo_full");

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a
// grant-level reference model; a second instance covers MAX_BURST=1 with two requesters.
module tb_fifo_wr_arbiter;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic             fifo_w_en;
    logic [W-1:0]     fifo_w_data;
    logic             fifo_full = 1'b0;
    logic             busy;
    logic [1:0]       owner;

    logic [1:0]       b_valid = '0;
    logic [15:0]      b_data = 16'h2211;
    logic [1:0]       b_ready;
    logic             b_en;
    logic [7:0]       b_wdata;
    logic             b_full = 1'b0;
    logic             b_busy;
    logic [0:0]       b_owner;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_w_en(fifo_w_en), .fifo_w_data(fifo_w_data),
        .fifo_full(fifo_full), .busy(busy), .owner(owner)
    );

    fifo_wr_arbiter #(.N_REQ(2), .WIDTH(8), .MAX_BURST(1)) dut_mb1 (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data),
        .req_ready(b_ready), .fifo_w_en(b_en), .fifo_w_data(b_wdata),
        .fifo_full(b_full), .busy(b_busy), .owner(b_owner)
    );

    int total = 0;
    int bad   = 0;

    // Producer state: requester i offers base[i]+seq[i] while it has words left and its gate is open.
    int          remaining [N];
    int          seq [N];
    logic [31:0] base [N];
    logic [N-1:0] gate = '0;

    // Reference model: who holds the grant (-1 = nobody), pushes in this grant, last grantee.
    int         m_grant = -1;
    int         m_cnt   = 0;
    int         m_last  = N - 1;
    logic [1:0] m_owner = 2'd0;

    logic         e_en;
    logic [N-1:0] e_rdy;
    logic [W-1:0] e_data;
    logic [1:0]   e_owner;
    logic         e_busy;

    logic [W-1:0] exp_q[$];

    function automatic logic [31:0] word_of(input int i);
        return base[i] + 32'(seq[i]);
    endfunction

    task automatic init_src(input int r0, input int r1, input int r2);
        remaining[0] = r0;
        remaining[1] = r1;
        remaining[2] = r2;
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            base[i] = 32'(i + 1) << 28;
        end
    endtask

    // Drives one clock cycle at the falling edge, publishes expectations, then advances the model.
    task automatic cycle(input logic r, input logic full);
        logic [N-1:0] v;
        int pick;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            v[i] = gate[i] && (remaining[i] > 0);
            req_data[i*W +: W] = word_of(i);
        end
        rst       = r;
        fifo_full = full;
        req_valid = v;
        e_owner = m_owner;
        e_busy  = (m_grant >= 0);
        e_en    = !r && (m_grant >= 0) && v[m_grant] && !full;
        e_rdy   = e_en ? (3'b001 << m_grant) : 3'b000;
        e_data  = word_of(int'(m_owner));
        #1;
        if (r) begin
            m_grant = -1;
            m_owner = 2'd0;
            m_last  = N - 1;
            m_cnt   = 0;
        end else if (m_grant < 0) begin
            if (|v) begin
                pick = -1;
                for (int k = 1; k <= N; k++)
                    if (pick < 0 && v[(m_last + k) % N]) pick = (m_last + k) % N;
                m_grant = pick;
                m_owner = pick[1:0];
                m_cnt   = 0;
            end
        end else if (!full) begin
            if (!v[m_grant]) begin
                m_last  = m_grant;
                m_grant = -1;
            end else begin
                remaining[m_grant]--;
                seq[m_grant]++;
                m_cnt++;
                if (m_cnt == MB) begin
                    m_last  = m_grant;
                    m_grant = -1;
                end
            end
        end
    endtask

    task automatic test_reset();
        init_src(5, 5, 5);
        gate = 3'b111;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)));
            total++;
            if (fifo_w_en !== 1'b0 || req_ready !== 3'b000) begin
                bad++;
                $display("FAIL reset_outputs k=%0d en=%b rdy=%b required en=0 rdy=000", k, fifo_w_en, req_ready);
            end
            if (k > 0) begin
                total++;
                if (owner !== 2'd0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_state k=%0d owner=%0d busy=%b required owner=0 busy=0", k, owner, busy);
                end
            end
        end
        cycle(1'b0, 1'b0);
        total++;
        if (busy !== 1'b0 || fifo_w_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b en=%b required busy=0 en=0", busy, fifo_w_en);
        end
        cycle(1'b0, 1'b0);
        total++;
        if (busy !== 1'b1 || owner !== 2'd0 || req_ready !== 3'b001 || fifo_w_data !== 32'h1000_0000) begin
            bad++;
            $display("FAIL reset_first_grant busy=%b owner=%0d rdy=%b data=%h required 1 0 001 10000000",
                     busy, owner, req_ready, fifo_w_data);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] want;
        init_src(0, 6, 0);
        base[1] = 32'hA0;
        gate = 3'b010;
        cycle(1'b1, 1'b0);
        exp_q.delete();
        for (int k = 0; k < 6; k++) exp_q.push_back(32'hA0 + k);
        for (int c = 0; c < 12; c++) begin
            cycle(1'b0, 1'b0);
            total++;
            if (fifo_w_en !== e_en || req_ready !== e_rdy) begin
                bad++;
                $display("FAIL single_push c=%0d en=%b rdy=%b required en=%b rdy=%b", c, fifo_w_en, req_ready, e_en, e_rdy);
            end
            total++;
            if (owner !== e_owner || busy !== e_busy) begin
                bad++;
                $display("FAIL single_state c=%0d owner=%0d busy=%b required owner=%0d busy=%b", c, owner, busy, e_owner, e_busy);
            end
            if (fifo_w_en === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL single_data c=%0d got extra push %h required none", c, fifo_w_data);
                end else begin
                    want = exp_q.pop_front();
                    if (fifo_w_data !== want) begin
                        bad++;
                        $display("FAIL single_data c=%0d got %h required %h", c, fifo_w_data, want);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL single_count words left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_contention();
        logic [W-1:0] want;
        logic want_en;
        init_src(100, 100, 100);
        gate = 3'b111;
        cycle(1'b1, 1'b0);
        exp_q.delete();
        for (int k = 0; k < 36; k++) exp_q.push_back(32'(1) << ((k / 4) % 3));
        for (int c = 0; c < 45; c++) begin
            cycle(1'b0, 1'b0);
            want_en = (c % 5) != 0;
            total++;
            if (fifo_w_en !== want_en || fifo_w_en !== e_en || req_ready !== e_rdy) begin
                bad++;
                $display("FAIL contention_pattern c=%0d en=%b rdy=%b required en=%b rdy=%b", c, fifo_w_en, req_ready, want_en, e_rdy);
            end
            if (fifo_w_en === 1'b1 && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                total++;
                if (32'(req_ready) !== want || fifo_w_data !== e_data) begin
                    bad++;
                    $display("FAIL contention_order c=%0d rdy=%b data=%h required rdy=%b data=%h", c, req_ready, fifo_w_data, want[2:0], e_data);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL contention_count grants left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic full_c;
        int pushes_after;
        pushes_after = 0;
        init_src(4, 50, 50);
        gate = 3'b111;
        cycle(1'b1, 1'b0);
        for (int c = 0; c < 13; c++) begin
            gate   = {2'($urandom_range(0, 3)), 1'b1};
            full_c = (c >= 3 && c <= 7);
            cycle(1'b0, full_c);
            total++;
            if (fifo_w_en !== e_en || req_ready !== e_rdy || owner !== e_owner || busy !== e_busy) begin
                bad++;
                $display("FAIL bp_model c=%0d en=%b rdy=%b owner=%0d busy=%b required %b %b %0d %b",
                         c, fifo_w_en, req_ready, owner, busy, e_en, e_rdy, e_owner, e_busy);
            end
            if (full_c) begin
                total++;
                if (fifo_w_en !== 1'b0 || req_ready !== 3'b000 || owner !== 2'd0) begin
                    bad++;
                    $display("FAIL bp_stall c=%0d en=%b rdy=%b owner=%0d required 0 000 0", c, fifo_w_en, req_ready, owner);
                end
            end
            if (c >= 8 && req_ready[0] === 1'b1) pushes_after++;
            if (c == 10) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_exit busy=%b required 0", busy);
                end
            end
        end
        total++;
        if (pushes_after != 2) begin
            bad++;
            $display("FAIL bp_resume pushes=%0d required 2", pushes_after);
        end
    endtask

    task automatic test_early_release();
        init_src(10, 10, 1);
        gate = 3'b100;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        gate = 3'b111;
        cycle(1'b0, 1'b0);
        total++;
        if (req_ready !== 3'b100) begin
            bad++;
            $display("FAIL early_push rdy=%b required 100", req_ready);
        end
        cycle(1'b0, 1'b0);
        total++;
        if (fifo_w_en !== 1'b0 || busy !== 1'b1 || owner !== 2'd2) begin
            bad++;
            $display("FAIL early_drop en=%b busy=%b owner=%0d required 0 1 2", fifo_w_en, busy, owner);
        end
        cycle(1'b0, 1'b0);
        total++;
        if (busy !== 1'b0 || fifo_w_en !== 1'b0) begin
            bad++;
            $display("FAIL early_idle busy=%b en=%b required 0 0", busy, fifo_w_en);
        end
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, 1'b0);
            total++;
            if (req_ready !== ((c < 4) ? 3'b001 : 3'b000) || req_ready !== e_rdy) begin
                bad++;
                $display("FAIL early_regrant c=%0d rdy=%b required %b", c, req_ready, (c < 4) ? 3'b001 : 3'b000);
            end
        end
    endtask

    task automatic test_reset_mid();
        init_src(10, 10, 10);
        gate = 3'b010;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            cycle(1'b0, 1'b0);
            total++;
            if (req_ready !== 3'b010) begin
                bad++;
                $display("FAIL rmid_push c=%0d rdy=%b required 010", c, req_ready);
            end
        end
        cycle(1'b1, 1'b0);
        total++;
        if (fifo_w_en !== 1'b0 || req_ready !== 3'b000) begin
            bad++;
            $display("FAIL rmid_reset_cycle en=%b rdy=%b required 0 000", fifo_w_en, req_ready);
        end
        gate = 3'b111;
        cycle(1'b0, 1'b0);
        total++;
        if (owner !== 2'd0 || busy !== 1'b0 || fifo_w_en !== 1'b0) begin
            bad++;
            $display("FAIL rmid_after owner=%0d busy=%b en=%b required 0 0 0", owner, busy, fifo_w_en);
        end
        cycle(1'b0, 1'b0);
        total++;
        if (busy !== 1'b1 || owner !== 2'd0 || req_ready !== 3'b001) begin
            bad++;
            $display("FAIL rmid_regrant busy=%b owner=%0d rdy=%b required 1 0 001", busy, owner, req_ready);
        end
    endtask

    task automatic test_random();
        init_src(1000, 1000, 1000);
        cycle(1'b1, 1'b0);
        for (int c = 0; c < 300; c++) begin
            gate = 3'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) == 0));
            total++;
            if (fifo_w_en !== e_en || req_ready !== e_rdy || owner !== e_owner || busy !== e_busy) begin
                bad++;
                $display("FAIL rand_model c=%0d en=%b rdy=%b owner=%0d busy=%b required %b %b %0d %b",
                         c, fifo_w_en, req_ready, owner, busy, e_en, e_rdy, e_owner, e_busy);
            end
            if (e_en) begin
                total++;
                if (fifo_w_data !== e_data) begin
                    bad++;
                    $display("FAIL rand_data c=%0d got %h required %h", c, fifo_w_data, e_data);
                end
            end
        end
    endtask

    task automatic test_mb1();
        logic want_en;
        int k;
        @(negedge clk);
        rst     = 1'b1;
        b_valid = 2'b11;
        b_full  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            want_en = (c % 2) == 1;
            k = c / 2;
            total++;
            if (b_en !== want_en) begin
                bad++;
                $display("FAIL mb1_pattern c=%0d en=%b required %b", c, b_en, want_en);
            end
            if (want_en) begin
                total++;
                if (b_owner !== 1'(k % 2) || b_ready !== (2'b01 << (k % 2)) ||
                    b_wdata !== ((k % 2 == 0) ? 8'h11 : 8'h22)) begin
                    bad++;
                    $display("FAIL mb1_owner c=%0d owner=%0d rdy=%b data=%h required owner=%0d", c, b_owner, b_ready, b_wdata, k % 2);
                end
            end
        end
    endtask

    initial begin
        init_src(0, 0, 0);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_release();
        test_reset_mid();
        test_random();
        test_mb1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
